// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying a decoded instruction
// (opaque payload plus control) between pipeline stages.
interface pipe_stage_skid_if #(
  parameter int PAYLOAD_W = 100,
  parameter int CTRL_W    = 11
);
  logic                 valid;
  logic                 ready;
  logic [PAYLOAD_W-1:0] data;
  logic [CTRL_W-1:0]    ctrl;

  modport master (
    output valid,
    output data,
    output ctrl,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    input  ctrl,
    output ready
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Decode-to-execute stage register with a two-entry skid buffer,
// synchronous flush and saturating stall/bubble statistics.
module pipe_stage_skid #(
  parameter int PAYLOAD_W = 100,
  parameter int CTRL_W    = 11,
  parameter int CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_stage_skid_if.slave     in_if,
  pipe_stage_skid_if.master    out_if,
  input  logic                 flush,
  input  logic                 clr_stats,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state;
  logic [PAYLOAD_W-1:0] main_data;
  logic [CTRL_W-1:0]    main_ctrl;
  logic [PAYLOAD_W-1:0] skid_data;
  logic [CTRL_W-1:0]    skid_ctrl;

  logic in_ready;
  logic out_valid;
  logic accept;
  logic take;
  logic stall;
  logic bubble;

  // Handshake flags depend on registered state only.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);

  assign accept = in_if.valid & in_ready;
  assign take   = out_valid & out_if.ready;
  assign stall  = out_valid & ~out_if.ready;
  assign bubble = ~out_valid & out_if.ready;

  assign in_if.ready  = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.data  = main_data;
  assign out_if.ctrl  = out_valid ? main_ctrl : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            main_data <= in_if.data;
            main_ctrl <= in_if.ctrl;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && take) begin
            main_data <= in_if.data;
            main_ctrl <= in_if.ctrl;
          end else if (accept) begin
            skid_data <= in_if.data;
            skid_ctrl <= in_if.ctrl;
            state     <= FULL;
          end else if (take) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (take) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            state     <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (clr_stats) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + 1'b1;
      if (bubble && bubble_cnt != '1)
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule
